// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
// A two-state run/idle machine gates fetch; stalls hold everything and redirects insert one bubble.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc4_d         = pc4_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      StIdle: begin
        instr_d = NOP_WORD;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
        if (start_i) state_d = StRun;
      end
      StRun: begin
        if (!start_i) begin
          // Leaving RUN fetches nothing on this edge.
          state_d = StIdle;
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (stall_i) begin
          // Hold everything; ID re-presents any redirect once the stall clears.
        end else if (branch_taken_i || jump_i) begin
          pc_d    = (branch_taken_i ? branch_target_i : jump_target_i) & ~32'h3;
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else begin
          pc_d          = pc_plus4;
          instr_d       = imem_data_i;
          pc4_d         = pc_plus4;
          valid_d       = 1'b1;
          fetch_count_d = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q
                                                           : fetch_count_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_WORD;
      pc4_q         <= 32'd0;
      valid_q       <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc4_q         <= pc4_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign ifid_instr_o  = instr_q;
  assign ifid_pc4_o    = pc4_q;
  assign ifid_valid_o  = valid_q;
  assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then random stimulus
// checked every cycle against a behavioural model of the fetch rules.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, start, stall, br, jmp;
  logic [31:0] br_tgt, j_tgt;
  logic [31:0] imem_addr, imem_data, pc, ifid_instr, ifid_pc4, fetch_count;
  logic        ifid_valid;

  logic [31:0] mem [256];
  assign imem_data = mem[imem_addr[9:2]];

  always #5 clk = ~clk;

  if_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stall_i        (stall),
    .branch_taken_i (br),
    .branch_target_i(br_tgt),
    .jump_i         (jmp),
    .jump_target_i  (j_tgt),
    .imem_addr_o    (imem_addr),
    .imem_data_i    (imem_data),
    .pc_o           (pc),
    .ifid_instr_o   (ifid_instr),
    .ifid_pc4_o     (ifid_pc4),
    .ifid_valid_o   (ifid_valid),
    .fetch_count_o  (fetch_count)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the architectural effect of one clock edge.
  bit          m_run;
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  task automatic m_bubble();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0;
      m_pc  = 32'h0;
      m_cnt = 32'h0;
      m_bubble();
    end else if (!m_run) begin
      m_bubble();
      m_run = start;
    end else if (!start) begin
      m_bubble();
      m_run = 1'b0;
    end else if (stall) begin
      // nothing moves
    end else if (br || jmp) begin
      m_pc = {(br ? br_tgt[31:2] : j_tgt[31:2]), 2'b00};
      m_bubble();
    end else begin
      m_instr = mem[m_pc[9:2]];
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc4", ifid_pc4, m_pc4);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("fetch_count", fetch_count, m_cnt);
    end
  end

  task automatic cyc(input logic r, input logic s, input logic st, input logic b,
                     input logic j, input logic [31:0] bt, input logic [31:0] jt);
    rst = r; start = s; stall = st; br = b; jmp = j; br_tgt = bt; j_tgt = jt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;

    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_count", fetch_count, 32'h0);

    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("start_no_fetch", pc, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("run2_pc", pc, 32'd8);
    chk("run2_instr", ifid_instr, 32'h2009_0003);
    chk("run2_pc4", ifid_pc4, 32'd8);
    chk("run2_count", fetch_count, 32'd2);

    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0, 0, 0);
      chk("stall_pc", pc, 32'd12);
      chk("stall_instr", ifid_instr, mem[2]);
      chk("stall_count", fetch_count, 32'd3);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("post_stall_pc", pc, 32'd16);

    cyc(0, 1, 0, 1, 0, 32'h41, 0);
    chk("br_pc", pc, 32'h40);
    chk("br_valid", {31'd0, ifid_valid}, 32'd0);
    chk("br_instr", ifid_instr, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("br_tgt_instr", ifid_instr, mem[16]);
    chk("br_tgt_pc4", ifid_pc4, 32'h44);

    cyc(0, 1, 1, 1, 1, 32'h80, 32'hC0);
    chk("stall_redirect_pc", pc, 32'h44);
    cyc(0, 1, 0, 1, 1, 32'h80, 32'hC0);
    chk("br_wins_pc", pc, 32'h80);

    cyc(0, 1, 0, 0, 1, 0, 32'h14);
    chk("jmp_pc", pc, 32'd20);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("idle_pc", pc, 32'd20);
    chk("idle_valid", {31'd0, ifid_valid}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("resume_instr", ifid_instr, mem[5]);
    chk("resume_pc4", ifid_pc4, 32'd24);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_count", fetch_count, 32'h0);
    chk("midrst_valid", {31'd0, ifid_valid}, 32'd0);

    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 32'hFFFF_FFFC);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", ifid_pc4, 32'h0);
    chk("wrap_instr", ifid_instr, mem[255]);

    // Saturation: preload the counter and look at its next value on a fetch edge.
    chk_en = 1'b0;
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    chk("sat_next", dut.fetch_count_d, 32'hFFFF_FFFF);
    release dut.fetch_count_q;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] bt, jt;
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      jt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8),
          ($urandom_range(0, 99) < 8), bt, jt);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
